// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//
// Purpose:
//   Display stage for the stopwatch counters. Scans four packed hex/BCD digits
//   onto one multiplexed common-line 4-digit 7-segment display. The digit and
//   decimal-point inputs are captured into shadow registers once per frame
//   (at the end of the digit-3 slot), so a counter rollover never shows up
//   half-way through a scan. Optional leading-zero blanking on d3..d1.
//
// Optional feature:
//   SEG_DIM_EN - when defined, adds the 'dim' port and an 8-step PWM that
//                blanks line/seg/dp for part of every 8-cycle window.
//
// Parameters:
//   SCAN_DIV    clk0 cycles per digit slot (multiple of 8, >= 16)
//
// Ports:
//   clk0        in   system clock, all state on posedge
//   reset_sw    in   asynchronous active-high reset
//   bcd[15:0]   in   {d3,d2,d1,d0}; d0 is the rightmost digit
//   dp_mask[3:0]in   bit i lights the decimal point of digit i
//   blank_lz    in   1 = blank leading zeros on d3..d1 (sampled live)
//   dim[2:0]    in   brightness reduction, 0 = full (SEG_DIM_EN only)
//   seg[6:0]    out  active-high segments {a,b,c,d,e,f,g}, registered
//   dp          out  active-high decimal point, registered
//   line[3:0]   out  one-hot digit select, bit i = digit i, registered
//   frame_tick  out  one-cycle pulse when a new frame's inputs are latched
//
// Handshake: there is no valid/ready pair; the outputs are a free-running
//   registered stream, one new value per clk0 cycle, reflecting the scan
//   position (idx/cnt) and shadow contents of the previous cycle.
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
    parameter int unsigned SCAN_DIV = 524288
) (
    input  logic        clk0,
    input  logic        reset_sw,
    input  logic [15:0] bcd,
    input  logic [3:0]  dp_mask,
    input  logic        blank_lz,
`ifdef SEG_DIM_EN
    input  logic [2:0]  dim,
`endif
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  line,
    output logic        frame_tick
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [15:0]   sh_bcd;
    logic [3:0]    sh_dp;

    logic          cnt_last;
    logic [3:0]    cur_digit;
    logic          blank_dig;
    logic [6:0]    seg_d;
    logic          dp_d;
    logic [3:0]    line_d;

    assign cnt_last = (cnt == CNT_LAST);

    function automatic logic [6:0] pat(input logic [3:0] v);
        logic [6:0] p;
        case (v)
            4'h0: p = 7'b1111110;
            4'h1: p = 7'b0110000;
            4'h2: p = 7'b1101101;
            4'h3: p = 7'b1111001;
            4'h4: p = 7'b0110011;
            4'h5: p = 7'b1011011;
            4'h6: p = 7'b1011111;
            4'h7: p = 7'b1110010;
            4'h8: p = 7'b1111111;
            4'h9: p = 7'b1111011;
            4'hA: p = 7'b1110111;
            4'hB: p = 7'b0011111;
            4'hC: p = 7'b1001110;
            4'hD: p = 7'b0111101;
            4'hE: p = 7'b1001111;
            default: p = 7'b1000111;
        endcase
        return p;
    endfunction

    // Scan position and per-frame shadow capture.
    always_ff @(posedge clk0 or posedge reset_sw) begin
        if (reset_sw) begin
            cnt        <= '0;
            idx        <= 2'd0;
            sh_bcd     <= 16'h0000;
            sh_dp      <= 4'h0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= 1'b0;
            if (cnt_last) begin
                cnt <= '0;
                idx <= idx + 2'd1;
                // End of the digit-3 slot is the frame boundary.
                if (idx == 2'd3) begin
                    sh_bcd     <= bcd;
                    sh_dp      <= dp_mask;
                    frame_tick <= 1'b1;
                end
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Leading-zero blanking works on the shadow digits so the blank/unblank
    // decision is frame-stable; only blank_lz itself is live.
    always_comb begin
        cur_digit = sh_bcd[{idx, 2'b00} +: 4];
        blank_dig = 1'b0;
        if (blank_lz) begin
            case (idx)
                2'd3:    blank_dig = (sh_bcd[15:12] == 4'h0);
                2'd2:    blank_dig = (sh_bcd[15:8] == 8'h00);
                2'd1:    blank_dig = (sh_bcd[15:4] == 12'h000);
                default: blank_dig = 1'b0;
            endcase
        end
        seg_d  = blank_dig ? 7'b0000000 : pat(cur_digit);
        dp_d   = sh_dp[idx];
        line_d = 4'b0001 << idx;
`ifdef SEG_DIM_EN
        // On-level is 8-dim cycles out of each 8-cycle window of cnt.
        if ({1'b0, cnt[2:0]} >= (4'd8 - {1'b0, dim})) begin
            seg_d  = 7'b0000000;
            dp_d   = 1'b0;
            line_d = 4'b0000;
        end
`endif
    end

    always_ff @(posedge clk0 or posedge reset_sw) begin
        if (reset_sw) begin
            seg  <= 7'b0000000;
            dp   <= 1'b0;
            line <= 4'b0000;
        end else begin
            seg  <= seg_d;
            dp   <= dp_d;
            line <= line_d;
        end
    end

endmodule
